// File: rtl/mul_by_n_pkg.sv
// Shared types and helpers for the mul_by_n frequency multiplier.
package mul_by_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int N_DEFAULT = 7;
    localparam int W_DEFAULT = 16;

    // Accumulator increment: two op1 edges per output cycle.
    function automatic int two_n(input int n);
        return 2 * n;
    endfunction

    // Saturation value of a w-bit period counter.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/mul_edge_sync.sv
// Brings the slow reference ip2 into the ip1 domain and flags its rising edge.
module mul_edge_sync (
    input  logic ip1,
    input  logic reset,
    input  logic ip2,
    output logic ip2_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two-flop synchroniser plus one delay flop for rise detection.
    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ip2;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign ip2_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/mul_by_n.sv
// Frequency multiplier: measures the ip2 period in ip1 cycles and produces
// op1 at N times the ip2 frequency with a phase accumulator.
// Build option: MUL_PHASE_RESYNC_EN realigns op1 to every accepted ip2 edge;
// without it op1 runs phase-continuously across period updates.
//
// state | meaning
// IDLE  | no reference seen since reset/timeout, op1 held low
// ACQ   | one edge seen, waiting for a usable period measurement
// RUN   | locked, accumulator generating op1
module mul_by_n
    import mul_by_n_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         ip1,
    input  logic         reset,
    input  logic         ip2,
    output logic         op1,
    output logic         lock,
    output logic [W-1:0] period
);

    localparam logic [W:0]   TWO_N   = (W+1)'(two_n(N));
    localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));
    localparam logic [W-1:0] CNT_PRE = CNT_MAX - {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_state_next;
    logic         w_edge;
    logic [W-1:0] r_cnt;
    logic [W:0]   w_meas;
    logic         w_meas_ok;
    logic         w_timeout;
    logic [W:0]   r_acc;
    logic [W:0]   w_acc_sum;
    logic [W:0]   w_acc_step;
    logic         w_op1_step;
    logic [W-1:0] r_period;
    logic         r_op1;
    logic         w_lock;

    mul_edge_sync u_sync (
        .ip1      (ip1),
        .reset    (reset),
        .ip2      (ip2),
        .ip2_edge (w_edge)
    );

    // Ip1 cycles since the last edge; an edge closes the measurement window.
    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Measured period, timeout and one accumulator step (W+1 bits, no overflow).
    always_comb begin
        w_meas     = {1'b0, r_cnt} + {{W{1'b0}}, 1'b1};
        w_meas_ok  = (w_meas >= TWO_N);
        // Timeout fires on the cycle the counter arrives at its ceiling.
        w_timeout  = (r_cnt == CNT_PRE);
        w_acc_sum  = r_acc + TWO_N;
        w_acc_step = w_acc_sum;
        w_op1_step = r_op1;
        if (w_acc_sum >= {1'b0, r_period}) begin
            w_acc_step = w_acc_sum - {1'b0, r_period};
            w_op1_step = ~r_op1;
        end
    end

    // State register.
    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an edge always takes priority over a timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_edge) w_state_next = ACQ;
            end
            ACQ: begin
                if (w_edge) begin
                    if (w_meas_ok) w_state_next = RUN;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_edge) begin
                    if (!w_meas_ok) w_state_next = ACQ;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Accumulator, op1 and accepted period.
    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_op1    <= 1'b0;
            r_period <= '0;
        end else begin
            case (r_state)
                ACQ: begin
                    r_acc <= '0;
                    if (w_edge && w_meas_ok) begin
                        r_period <= w_meas[W-1:0];
                        r_op1    <= 1'b1;
                    end else begin
                        r_op1 <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_edge) begin
                        if (!w_meas_ok) begin
                            r_acc <= '0;
                            r_op1 <= 1'b0;
                        end else begin
                            r_period <= w_meas[W-1:0];
`ifdef MUL_PHASE_RESYNC_EN
                            r_acc <= '0;
                            r_op1 <= 1'b1;
`else
                            // Free-running phase: this cycle's step still uses the old period.
                            r_acc <= w_acc_step;
                            r_op1 <= w_op1_step;
`endif
                        end
                    end else if (w_timeout) begin
                        r_acc <= '0;
                        r_op1 <= 1'b0;
                    end else begin
                        r_acc <= w_acc_step;
                        r_op1 <= w_op1_step;
                    end
                end
                default: begin
                    r_acc <= '0;
                    r_op1 <= 1'b0;
                end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        w_lock = (r_state == RUN);
    end

    assign lock   = w_lock;
    assign op1    = r_op1;
    assign period = r_period;

endmodule

// File: tb/tb_mul_by_n.sv
module tb_mul_by_n;

    localparam int N       = 7;
    localparam int W       = 8;
    localparam int TWO_N   = 2 * N;
    localparam int CNT_MAX = (1 << W) - 1;

    logic         ip1;
    logic         reset;
    logic         ip2;
    logic         op1;
    logic         lock;
    logic [W-1:0] period;

    int n_checks = 0;
    int n_fail   = 0;

    mul_by_n #(.N(N), .W(W)) dut (
        .ip1    (ip1),
        .reset  (reset),
        .ip2    (ip2),
        .op1    (op1),
        .lock   (lock),
        .period (period)
    );

    initial begin
        ip1 = 1'b0;
        forever #5 ip1 = ~ip1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each locked stretch is a segment: after k cycles the phase is
    // a0 + k*2N, op1 has toggled floor(phase/P) times and the residue is phase mod P.
    int  cyc = 0;
    int  m_state = 0;          // 0 idle, 1 acquiring, 2 locked
    int  m_period = 0;
    int  m_last_edge = 0;
    int  seg_start = 0;
    int  seg_a0 = 0;
    int  seg_p = 1;
    bit  seg_op1 = 1'b0;
    bit  prev_ip2 = 1'b0;
    int  pend[$];
    bit  e_op1 = 1'b0;
    bit  e_lock = 1'b0;
    int  e_period = 0;

    always @(posedge ip1) begin
        int  meas;
        int  tot;
        bit  e_now;
        cyc++;
        if (reset) begin
            m_state     = 0;
            m_period    = 0;
            m_last_edge = cyc;
            prev_ip2    = 1'b0;
            pend.delete();
        end else begin
            e_now = (pend.size() != 0) && (pend[0] == cyc);
            if (e_now) void'(pend.pop_front());
            meas = cyc - m_last_edge;
            case (m_state)
                0: if (e_now) m_state = 1;
                1: begin
                    if (e_now) begin
                        if (meas >= TWO_N) begin
                            m_state = 2; m_period = meas;
                            seg_start = cyc; seg_a0 = 0; seg_op1 = 1'b1; seg_p = meas;
                        end
                    end else if (meas == CNT_MAX) begin
                        m_state = 0;
                    end
                end
                default: begin
                    if (e_now) begin
                        if (meas < TWO_N) begin
                            m_state = 1;
                        end else begin
`ifdef MUL_PHASE_RESYNC_EN
                            seg_start = cyc; seg_a0 = 0; seg_op1 = 1'b1;
`else
                            tot       = seg_a0 + (cyc - seg_start) * TWO_N;
                            seg_op1   = seg_op1 ^ bit'((tot / seg_p) % 2);
                            seg_a0    = tot % seg_p;
                            seg_start = cyc;
`endif
                            seg_p = meas; m_period = meas;
                        end
                    end else if (meas == CNT_MAX) begin
                        m_state = 0;
                    end
                end
            endcase
            if (e_now) m_last_edge = cyc;
            // A rise sampled at this edge is acted on two edges later.
            if (ip2 && !prev_ip2) pend.push_back(cyc + 2);
            prev_ip2 = ip2;
        end
        if (m_state == 2) begin
            tot   = seg_a0 + (cyc - seg_start) * TWO_N;
            e_op1 = seg_op1 ^ bit'((tot / seg_p) % 2);
        end else begin
            e_op1 = 1'b0;
        end
        e_lock   = (m_state == 2);
        e_period = m_period;
    end

    // Per-cycle comparison against the model.
    always @(negedge ip1) begin
        if (reset) begin
            chk("op1_in_reset", int'(op1), 0);
            chk("lock_in_reset", int'(lock), 0);
            chk("period_in_reset", int'(period), 0);
        end else begin
            chk("op1_vs_model", int'(op1), int'(e_op1));
            chk("lock_vs_model", int'(lock), int'(e_lock));
            chk("period_vs_model", int'(period), e_period);
        end
    end

    // ---------------- stimulus ----------------
    int tog, gmin, gmax;

    task automatic ip2_period(input int p, input int count);
        for (int i = 0; i < count; i++) begin
            ip2 = 1'b1;
            repeat (p / 2) @(negedge ip1);
            ip2 = 1'b0;
            repeat (p - p / 2) @(negedge ip1);
        end
    endtask

    task automatic measure(input int ncyc, output int t, output int mn, output int mx);
        int   last;
        logic prev;
        last = -1; t = 0; mn = 1 << 30; mx = 0;
        @(negedge ip1);
        prev = op1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge ip1);
            if (op1 !== prev) begin
                t++;
                if (last >= 0) begin
                    if (i - last < mn) mn = i - last;
                    if (i - last > mx) mx = i - last;
                end
                last = i;
            end
            prev = op1;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ip2   = 1'b0;
        repeat (3) @(negedge ip1);
        chk("reset_op1", int'(op1), 0);
        chk("reset_lock", int'(lock), 0);
        chk("reset_period", int'(period), 0);
        reset = 1'b0;
        repeat (5) @(negedge ip1);

        // Integer ratio: 140 / 14 = 10 cycles per toggle.
        fork
            ip2_period(140, 6);
            begin
                repeat (420) @(negedge ip1);
                measure(280, tog, gmin, gmax);
            end
        join
        chk("int_period", int'(period), 140);
        chk("int_lock", int'(lock), 1);
        chk("int_toggles_280", tog, 28);
        chk("int_gap_min", gmin, 10);
        chk("int_gap_max", gmax, 10);

        // Period step 140 -> 154.
        ip2_period(154, 4);
        chk("step_period", int'(period), 154);
        chk("step_lock", int'(lock), 1);

        // Too fast: period 10 < 14.
        ip2_period(10, 4);
        chk("fast_lock", int'(lock), 0);
        chk("fast_op1", int'(op1), 0);
        chk("fast_period_kept", int'(period), 154);

        // Fractional ratio: 100 / 14, spacing 7 or 8, 140 toggles per 10 periods.
        fork
            ip2_period(100, 14);
            begin
                repeat (300) @(negedge ip1);
                measure(1000, tog, gmin, gmax);
            end
        join
        chk("frac_period", int'(period), 100);
        chk("frac_toggles_1000", tog, 140);
        chk("frac_gap_min", gmin, 7);
        chk("frac_gap_max", gmax, 8);

        // Asynchronous reset while locked.
        chk("pre_reset_lock", int'(lock), 1);
        @(posedge ip1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_op1", int'(op1), 0);
        chk("async_rst_lock", int'(lock), 0);
        chk("async_rst_period", int'(period), 0);
        @(negedge ip1);
        @(negedge ip1);
        reset = 1'b0;
        repeat (5) @(negedge ip1);

        // First edge after release only reaches ACQ.
        ip2_period(140, 1);
        chk("one_edge_no_lock", int'(lock), 0);

        // Second edge locks three cycles after the rise.
        ip2 = 1'b1;
        n = 0;
        while (!lock && n < 20) begin
            @(negedge ip1);
            n++;
        end
        chk("lock_latency", n, 3);

        // Stop ip2: lock holds for 255 cycles after the last edge.
        n = 0;
        while (lock && n < 600) begin
            @(negedge ip1);
            n++;
            if (n == 70) ip2 = 1'b0;
        end
        chk("timeout_lock_cycles", n, 255);
        chk("timeout_op1", int'(op1), 0);
        chk("timeout_period_kept", int'(period), 140);

        repeat (5) @(negedge ip1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_by_n.md
Name: mul_by_n

Overview:
- Frequency multiplier, the counterpart of the divide-by-N counter block.
- Measures the period of slow input ip2 in fast-clock (ip1) cycles and synthesises op1 at N times the ip2 frequency.
- Uses a phase accumulator, so no divider is needed.
- Sits beside the divider blocks to regenerate fast clocks from slow references in the benchmark set.

Parameters:
- N, 7, multiplication factor; 1 <= N and 2*N < 2^W.
- W, 16, width of the period counter, the measured period and the accumulator base.

Ports:
- ip1  input  1  fast clock; all logic on posedge ip1.
- reset  input  1  asynchronous, active-high reset.
- ip2  input  1  slow reference, asynchronous to ip1.
- op1  output  1  multiplied output, N cycles per ip2 period.
- lock  output  1  high while op1 is valid (state RUN).
- period  output  W  last accepted ip2 period in ip1 cycles.

Behaviour:
- Reset (async, active-high): op1=0, lock=0, period=0, cnt=0, acc=0, state=IDLE, synchroniser flops=0.
- Input path: ip2 goes through a 2-FF synchroniser (s1, s2), then a third flop s3.
  - edge = s2 & ~s3, a one-cycle pulse.
  - edge asserts 3 ip1 cycles after an ip2 rise that meets setup.
- Period counter:
  - cnt increments every cycle and saturates at 2^W-1.
  - On edge: meas = cnt+1 and cnt <= 0.
  - meas is the ip1 cycle count between consecutive edges.
- State IDLE:
  - op1=0, lock=0.
  - edge goes to ACQ; cnt is cleared.
- State ACQ:
  - op1=0, lock=0.
  - On edge with meas >= 2N: period <= meas, acc <= 0, op1 <= 1, lock <= 1, go to RUN.
  - On edge with meas < 2N: stay in ACQ (input too fast).
- State RUN: each cycle, acc_next = acc + 2N (acc is W+1 bits wide).
  - If acc_next >= period: acc <= acc_next - period and op1 toggles.
  - Otherwise acc <= acc_next.
  - Result: exactly 2N toggles per period cycles. Toggle spacing is floor or ceil of period/(2N).
- On edge in RUN:
  - period <= meas. With MUL_PHASE_RESYNC_EN, phase resyncs as described under Optional Feature.
  - If meas < 2N: go to ACQ, lock=0, op1=0, period unchanged.
- Timeout: cnt reaches 2^W-1 in ACQ or RUN -> IDLE, lock=0, op1=0, acc=0.
- Simultaneous events:
  - edge and an accumulator toggle in the same cycle: edge wins.
  - edge and timeout in the same cycle: edge wins; cnt is cleared.
- reset during RUN: immediate return to reset values. The first edge after release only enters ACQ.
- Widths: comparison and subtraction use W+1 bits, so no overflow is possible since 2N < period <= 2^W-1.

Optional Feature:
- Macro: MUL_PHASE_RESYNC_EN.
- Defined: on every edge in RUN with a valid meas, acc <= 0 and op1 <= 1. The op1 rising edge is aligned to each synchronised ip2 rise; any partial cycle is truncated.
- Undefined: edge in RUN only updates period. acc and op1 run free, giving a phase-continuous output with no glitch at update.

Decomposition:
- Package mul_by_n_pkg:
  - state typedef {IDLE, ACQ, RUN}.
  - localparam TWO_N = 2*N.
  - CNT_MAX = 2^W-1.
- Sub-module mul_edge_sync: 2-FF synchroniser plus edge detect.
  - Ports: ip1, reset, ip2 in; edge out.

Test Plan:
- Reset: reset high mid-RUN -> op1=0, lock=0, period=0 on the same edge (async); ip2 edges after release -> lock rises only on the second edge.
- Integer ratio: N=7, ip2 period 140 ip1 cycles -> period=140; op1 toggles every 10 cycles; op1 has 7 full periods of 20 cycles per ip2 period; lock=1.
- Fractional ratio: ip2 period 100 -> 14 toggles per 100 cycles; spacing alternates 7 and 8; zero accumulated drift over 10 ip2 periods.
- Too fast: ip2 period 10 (< 14) while in RUN -> lock=0, op1=0, state ACQ; period stays at its previous value.
- Timeout: W=8, stop ip2 after lock -> 255 cycles later lock=0, op1=0, IDLE.
- Resync (MUL_PHASE_RESYNC_EN set vs unset): ip2 period stepped 140 -> 154.
  - Set: op1 goes to 1 three cycles after each ip2 rise.
  - Unset: op1 continues without a forced edge; period=154 after the step.
